// File: rtl/mdio_responder.sv
// Clause-22 MDIO target: oversamples MDC/MDIO on clk, decodes read/write frames, drives read data.
// Optional macro MDIO_RESPONDER_PHYAD_FILTER_EN: answer only PHY_ADDR; otherwise every PHYAD matches.
module mdio_responder #(
  parameter logic [4:0] PHY_ADDR = 5'd1,
  parameter int         PRE_MIN  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mdc_i,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_out_en,
  output logic [4:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_wr,
  output logic        reg_rd,
  input  logic [15:0] reg_rdata,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_PRE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_WDATA, S_RDATA
  } state_t;

  localparam logic [5:0] PRE_MIN_C = 6'(PRE_MIN);

  logic [1:0]  mdc_sync_q;
  logic [1:0]  mdio_sync_q;
  logic        mdc_prev_q;
  logic        edge_q;
  logic        mdio_q;
  state_t      state_q;
  logic [5:0]  pre_cnt_q;
  logic [4:0]  bit_q;
  logic        is_rd_q;
  logic        match_q;
  logic        pend_q;
  logic [3:0]  phyad_q;
  logic [3:0]  regad_q;
  logic [15:0] shift_q;

  logic [4:0]  phyad_d;
  logic [4:0]  regad_d;
  logic [15:0] shift_in_d;
  logic        match_d;
  logic        drive_d;

  assign phyad_d    = {phyad_q, mdio_q};
  assign regad_d    = {regad_q, mdio_q};
  assign shift_in_d = {shift_q[14:0], mdio_q};
  assign drive_d    = is_rd_q & match_q;

`ifdef MDIO_RESPONDER_PHYAD_FILTER_EN
  assign match_d = (phyad_d == PHY_ADDR);
`else
  // Broadcast emulation: the address compare is forced true.
  assign match_d = (phyad_d == PHY_ADDR) | 1'b1;
`endif

  // Input stage: 2-FF synchronizers, then a registered MDC rise and the MDIO value sampled with it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mdc_sync_q  <= 2'b00;
      mdio_sync_q <= 2'b11;
      mdc_prev_q  <= 1'b0;
      edge_q      <= 1'b0;
      mdio_q      <= 1'b1;
    end else begin
      mdc_sync_q  <= {mdc_sync_q[0], mdc_i};
      mdio_sync_q <= {mdio_sync_q[0], mdio_i};
      mdc_prev_q  <= mdc_sync_q[1];
      edge_q      <= mdc_sync_q[1] & ~mdc_prev_q;
      mdio_q      <= mdio_sync_q[1];
    end
  end

  // Frame decoder and all registered outputs; every transition happens on an MDC edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_PRE;
      pre_cnt_q   <= 6'd0;
      bit_q       <= 5'd0;
      is_rd_q     <= 1'b0;
      match_q     <= 1'b0;
      pend_q      <= 1'b0;
      phyad_q     <= 4'd0;
      regad_q     <= 4'd0;
      shift_q     <= 16'd0;
      mdio_o      <= 1'b1;
      mdio_out_en <= 1'b0;
      reg_addr    <= 5'd0;
      reg_wdata   <= 16'd0;
      reg_wr      <= 1'b0;
      reg_rd      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      reg_wr <= 1'b0;
      reg_rd <= 1'b0;
      if (edge_q) begin
        bit_q <= bit_q + 5'd1;
        case (state_q)
          S_PRE: begin
            if (mdio_q) begin
              if (pre_cnt_q != 6'h3F) pre_cnt_q <= pre_cnt_q + 6'd1;
            end else begin
              pre_cnt_q <= 6'd0;
              if (pre_cnt_q >= PRE_MIN_C) begin
                state_q <= S_ST;
                busy    <= 1'b1;
                bit_q   <= 5'd1;
              end
            end
          end
          S_ST: begin
            if (mdio_q) begin
              state_q <= S_OP;
            end else begin
              state_q   <= S_PRE;
              busy      <= 1'b0;
              pre_cnt_q <= 6'd0;
            end
          end
          S_OP: begin
            pend_q <= mdio_q;
            if (bit_q == 5'd3) begin
              // 10 = read, 01 = write; equal bits are illegal opcodes.
              if (pend_q != mdio_q) begin
                is_rd_q <= pend_q;
                state_q <= S_PHYAD;
              end else begin
                state_q   <= S_PRE;
                busy      <= 1'b0;
                pre_cnt_q <= 6'd0;
              end
            end
          end
          S_PHYAD: begin
            phyad_q <= phyad_d[3:0];
            if (bit_q == 5'd8) begin
              match_q <= match_d;
              state_q <= S_REGAD;
            end
          end
          S_REGAD: begin
            regad_q <= regad_d[3:0];
            if (bit_q == 5'd13) begin
              reg_addr <= regad_d;
              reg_rd   <= is_rd_q & match_q;
              state_q  <= S_TA;
            end
          end
          S_TA: begin
            pend_q <= mdio_q;
            if (bit_q == 5'd14) begin
              if (drive_d) begin
                shift_q     <= reg_rdata;
                mdio_out_en <= 1'b1;
                mdio_o      <= 1'b0;
              end
            end else if (is_rd_q) begin
              state_q <= S_RDATA;
              if (drive_d) begin
                mdio_o  <= shift_q[15];
                shift_q <= {shift_q[14:0], 1'b0};
              end
            end else if (pend_q && !mdio_q) begin
              state_q <= S_WDATA;
            end else begin
              state_q   <= S_PRE;
              busy      <= 1'b0;
              pre_cnt_q <= 6'd0;
            end
          end
          S_RDATA: begin
            if (bit_q == 5'd31) begin
              state_q     <= S_PRE;
              busy        <= 1'b0;
              pre_cnt_q   <= 6'd0;
              mdio_out_en <= 1'b0;
              mdio_o      <= 1'b1;
            end else if (mdio_out_en) begin
              mdio_o  <= shift_q[15];
              shift_q <= {shift_q[14:0], 1'b0};
            end
          end
          S_WDATA: begin
            shift_q <= shift_in_d;
            if (bit_q == 5'd31) begin
              if (match_q) begin
                reg_wdata <= shift_in_d;
                reg_wr    <= 1'b1;
              end
              state_q   <= S_PRE;
              busy      <= 1'b0;
              pre_cnt_q <= 6'd0;
            end
          end
          default: begin
            state_q     <= S_PRE;
            busy        <= 1'b0;
            pre_cnt_q   <= 6'd0;
            mdio_out_en <= 1'b0;
            mdio_o      <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/mdio_responder.md
# mdio_responder

MDIO/SMI management responder (PHY-side target) for IEEE 802.3 clause-22 frames. It oversamples MDC and MDIO on the system clock, decodes read and write frames, and exposes register accesses on a simple strobe interface. It drives read data back with tri-state control. It sits opposite the SMI management master: on the bench it stands in for the Ethernet PHY, and in designs it emulates a PHY register bank.

## Interface

Parameters:
- `PHY_ADDR`, default 5'd1: PHY address answered.
- `PRE_MIN`, default 32: consecutive 1 bits required before ST is accepted (1..63).

Ports (reset is synchronous and active-low):
- `clk` in 1: system clock, at least 8x MDC frequency.
- `rst` in 1: synchronous active-low reset.
- `mdc_i` in 1: MDC from the master, asynchronous.
- `mdio_i` in 1: MDIO pad input, asynchronous.
- `mdio_o` out 1: MDIO drive value.
- `mdio_out_en` out 1: 1 = drive the pad, 0 = release.
- `reg_addr` out 5: REGAD of the current frame.
- `reg_wdata` out 16: write data, valid with `reg_wr`.
- `reg_wr` out 1: one-clk write strobe.
- `reg_rd` out 1: one-clk read-request strobe.
- `reg_rdata` in 16: read data, captured one MDC period after `reg_rd`.
- `busy` out 1: frame in progress (ST seen, frame not yet finished or aborted).

## Operation

- **Input stage.** 2-FF synchronizers on `mdc_i` and `mdio_i`. A rising-edge detect on the synchronized MDC gives a 1-clk `edge`. All decoding happens on `edge` cycles.
- **Bit numbering.** Frame bits after the preamble are numbered n = 0..31:
  - ST: 0-1
  - OP: 2-3
  - PHYAD: 4-8
  - REGAD: 9-13
  - TA: 14-15
  - DATA: 16-31, MSB first
- **States:** PRE, ST, OP, PHYAD, REGAD, TA, WDATA, RDATA.
- **PRE.** A 6-bit saturating counter counts sampled 1s; a sampled 0 clears it. When the counter is ≥ `PRE_MIN` and a 0 is sampled, go to ST (this 0 is ST bit 0).
- **ST.** Bit 1 must be 1. Otherwise go to PRE with the counter cleared.
- **OP.** 10 = read, 01 = write. 00 or 11 aborts to PRE.
- **PHYAD.** Shift in 5 bits. `match` = (PHYAD == `PHY_ADDR`), subject to the Configuration section.
- **REGAD.** Shift in 5 bits. `reg_addr` updates on the bit-13 edge. On a read with match, `reg_rd` pulses in the same clk as the bit-13 edge.
- **TA, read with match.**
  - Bit-14 edge: capture `reg_rdata` into the shift register; assert `mdio_out_en` with `mdio_o` = 0.
  - Bit-15 edge: `mdio_o` = data[15].
  - Each later edge shifts out the next bit. Bit 0 is driven from the bit-30 edge.
  - Bit-31 edge: `mdio_out_en` = 0; go to PRE.
- **TA, write.** Sampled TA must be 10, otherwise abort to PRE with no strobe. Then shift 16 bits into WDATA. On the bit-31 edge, if match: `reg_wdata` updates and `reg_wr` pulses once.
- **No match.** The frame is tracked to bit 31. No strobes fire and `mdio_out_en` stays 0.
- **Return to PRE.** After bit 31 the preamble counter restarts at 0, so back-to-back frames each need their own preamble.
- **Idle outputs.** Outside read drive, `mdio_out_en` = 0 and `mdio_o` = 1.

## Timing

- Reset values:
  - `mdio_o` = 1, `mdio_out_en` = 0
  - `reg_addr` = 0, `reg_wdata` = 0
  - `reg_wr` = 0, `reg_rd` = 0
  - `busy` = 0
  - state = PRE, counter = 0
- Input-to-edge latency: 3 clk from the `mdc_i` rise to the `edge` cycle. Driven outputs change 1 clk after `edge`, so 4 clk after the MDC rise, and are stable well before the next MDC rise.
- `reg_rdata` must be valid from `reg_rd` + 1 clk until the bit-14 edge (≥ 1 MDC period).
- `busy` rises on the ST bit-0 edge. It falls on the bit-31 edge or on abort.
- `rst` low mid-frame: on the next clk all outputs return to reset values and the pad is released at once. The first frame after reset needs a full preamble.
- An MDC stall mid-frame holds state indefinitely; there is no timeout.

## Configuration

- `MDIO_RESPONDER_PHYAD_FILTER_EN`:
  - **Defined:** `match` = (PHYAD == `PHY_ADDR`); frames to other addresses are ignored as described above.
  - **Undefined:** `match` = 1 for every PHYAD, so the block answers all 32 addresses (broadcast emulation) and `PHY_ADDR` is unused.

## Test plan

- **Read.** Stimulus: 32 ones, then read PHYAD=1 REGAD=1, `reg_rdata`=16'h0004. Required:
  - `reg_rd` pulses once with `reg_addr`=1.
  - TA drives 0 on bit 15.
  - 16'h0004 returns MSB first.
  - `mdio_out_en` drops on the bit-31 edge.
- **Write.** Stimulus: write PHYAD=1 REGAD=31 data=16'h0007. Required: exactly one `reg_wr`, `reg_addr`=31, `reg_wdata`=16'h0007, `mdio_out_en` never 1.
- **Short preamble and bad fields.** 31-one preamble, ST=00, or OP=11 → no strobe, `busy` low afterwards; the next frame with a valid preamble is decoded normally.
- **Address filter.** PHYAD=2 with the filter compiled in → no strobes, pad released. With the macro undefined, the same frame yields `reg_wr`.
- **Write TA error.** TA=11 on a write → no `reg_wr`.
- **Reset mid-frame.** Assert `rst` low at read bit 20 → `mdio_out_en`=0 on the next clk; after release, a full read of 16'hFFE returns correctly.
